// File: rtl/pcrossbar_pkg.sv
// Shared constants, config-layout helpers, FSM states and CRC-8 step for pcrossbar.
package pcrossbar_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Field width per output: enable bit plus select.
    function automatic int calc_f(input int n_in);
        return $clog2(n_in) + 1;
    endfunction

    function automatic int calc_fpw(input int n_in);
        return 32 / calc_f(n_in);
    endfunction

    function automatic int calc_l(input int n_in, input int n_out);
        int fpw;
        fpw = calc_fpw(n_in);
        return (n_out + fpw - 1) / fpw;
    endfunction

    // One 32-bit word through CRC-8, MSB first.
    function automatic logic [7:0] crc8_word(input logic [7:0] crc, input logic [31:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/pcrossbar_mux.sv
// Registered N_IN:1 channel selector for one crossbar output; disabled or
// out-of-range selects drive zero.
module pcrossbar_mux #(
    parameter int N_IN  = 16,
    parameter int DW    = 1,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [N_IN*DW-1:0]   din,
    input  logic                 en,
    input  logic [SEL_W-1:0]     sel,
    output logic [DW-1:0]        dout
);

    localparam int              PW    = (2 ** SEL_W) * DW;
    localparam logic [SEL_W:0]  N_LIM = (SEL_W + 1)'(N_IN);

    // Pad to the full select range so every sel value indexes a real slot.
    logic [(2**SEL_W)-1:0][DW-1:0] din_p;
    logic                          hit;

    assign din_p = PW'(din);
    assign hit   = en && ({1'b0, sel} < N_LIM);

    always_ff @(posedge clk or posedge res) begin
        if (res) dout <= '0;
        else     dout <= hit ? din_p[sel] : '0;
    end

endmodule

// File: rtl/pcrossbar.sv
// Programmable crossbar: a shift-loaded shadow chain is committed atomically to
// the active routing config. Optional CRC-8 check on commit: PCROSSBAR_CRC_EN.
module pcrossbar
    import pcrossbar_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 16,
    parameter int DW    = 1
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [31:0]          prog_i,
    input  logic                 prog_shft,
    input  logic                 prog_commit,
    input  logic                 prog_abort,
    output logic [31:0]          prog_o,
    output logic                 cfg_err,
    output logic                 cfg_busy,
    input  logic [N_IN*DW-1:0]   din,
    output logic [N_OUT*DW-1:0]  dout
);

    localparam int SEL_W = $clog2(N_IN);
    localparam int F     = calc_f(N_IN);
    localparam int FPW   = calc_fpw(N_IN);
    localparam int L     = calc_l(N_IN, N_OUT);
`ifdef PCROSSBAR_CRC_EN
    localparam int C      = L + 1;
    localparam int CW_OFS = 1;
`else
    localparam int C      = L;
    localparam int CW_OFS = 0;
`endif
    localparam int               CNT_W = $clog2(C + 2);
    localparam logic [CNT_W-1:0] C_CNT = CNT_W'(C);
    localparam logic [CNT_W-1:0] C_SAT = CNT_W'(C + 1);

    logic [C-1:0][31:0]      shadow;
    logic [N_OUT-1:0][F-1:0] act;
    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    crc_ok;
    logic                    load_shift;
    logic                    do_shift;

    // Commit beats shift, abort beats both; in ERR shifting still feeds the chain.
    assign load_shift = prog_shft && !prog_abort && !prog_commit &&
                        (state == ST_IDLE || state == ST_LOAD);
    assign do_shift   = load_shift || (state == ST_ERR && prog_shft && !prog_abort);

    assign prog_o   = shadow[C-1];
    assign cfg_err  = (state == ST_ERR);
    assign cfg_busy = (state == ST_COMMIT);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            shadow <= '0;
        end else if (do_shift) begin
            shadow[0] <= prog_i;
            for (int j = 1; j < C; j++) shadow[j] <= shadow[j-1];
        end
    end

`ifdef PCROSSBAR_CRC_EN
    localparam logic [CNT_W-1:0] L_CNT = CNT_W'(L);
    logic [7:0] crc;

    // Only the first L counted words are config; the next one carries the CRC.
    always_ff @(posedge clk or posedge res) begin
        if (res)                                        crc <= '0;
        else if (state == ST_COMMIT)                    crc <= '0;
        else if (prog_abort)                            crc <= '0;
        else if (load_shift && cnt < L_CNT)             crc <= crc8_word(crc, prog_i);
    end

    assign crc_ok = (shadow[0][7:0] == crc);
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
                ST_ERR: begin
                    if (prog_abort) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (prog_abort) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (prog_commit) begin
                        state <= (cnt == C_CNT && crc_ok) ? ST_COMMIT : ST_ERR;
                    end else if (prog_shft) begin
                        state <= ST_LOAD;
                        if (cnt != C_SAT) cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Whole config copied in the single COMMIT cycle so outputs never see a mix.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            act <= '0;
        end else if (state == ST_COMMIT) begin
            for (int k = 0; k < N_OUT; k++)
                act[k] <= shadow[k/FPW + CW_OFS][(k%FPW)*F +: F];
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        pcrossbar_mux #(
            .N_IN  (N_IN),
            .DW    (DW),
            .SEL_W (SEL_W)
        ) u_mux (
            .clk  (clk),
            .res  (res),
            .din  (din),
            .en   (act[k][F-1]),
            .sel  (act[k][SEL_W-1:0]),
            .dout (dout[k*DW +: DW])
        );
    end

endmodule

// File: tb/tb_pcrossbar.sv
// Scoreboard bench for pcrossbar: a default instance and an N_IN=12 instance
// share one programming stream; expectations are queued with a due cycle.
module tb_pcrossbar;

`ifdef PCROSSBAR_CRC_EN
    localparam int C = 4;
`else
    localparam int C = 3;
`endif

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] prog_i;
    logic        prog_shft, prog_commit, prog_abort;
    logic [15:0] din;
    logic [31:0] po_a, po_b;
    logic        err_a, err_b, busy_a, busy_b;
    logic [15:0] dout_a, dout_b;

    pcrossbar u_a (
        .clk(clk), .res(res), .prog_i(prog_i), .prog_shft(prog_shft),
        .prog_commit(prog_commit), .prog_abort(prog_abort), .prog_o(po_a),
        .cfg_err(err_a), .cfg_busy(busy_a), .din(din), .dout(dout_a)
    );

    pcrossbar #(.N_IN(12)) u_b (
        .clk(clk), .res(res), .prog_i(prog_i), .prog_shft(prog_shft),
        .prog_commit(prog_commit), .prog_abort(prog_abort), .prog_o(po_b),
        .cfg_err(err_b), .cfg_busy(busy_b), .din(din[11:0]), .dout(dout_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       name;
        logic [15:0] da;
        logic [15:0] db;
        logic        err;
        logic        busy;
        logic [31:0] po;
        bit          chk_po;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   stim_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int dly, input string nm, input logic [15:0] da,
                             input logic [15:0] db, input logic err, input logic busy,
                             input logic [31:0] po, input bit chk_po);
        exp_t e;
        e.due = cyc + dly; e.name = nm; e.da = da; e.db = db;
        e.err = err; e.busy = busy; e.po = po; e.chk_po = chk_po;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift(input logic [31:0] w);
        prog_i = w; prog_shft = 1'b1;
        tick();
        prog_shft = 1'b0;
    endtask

`ifdef PCROSSBAR_CRC_EN
    // CRC-8 with zero init as the remainder of M(x)*x^8 modulo x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref(input logic [95:0] m);
        logic [103:0] r;
        r = {m, 8'h00};
        for (int i = 103; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        return r[7:0];
    endfunction

    task automatic load_cfg_crc(input logic [31:0] w2, input logic [31:0] w1,
                                input logic [31:0] w0, input logic [7:0] flip);
        shift(w2); shift(w1); shift(w0);
        shift({24'h0, crc_ref({w2, w1, w0}) ^ flip});
    endtask
`endif

    task automatic load_cfg(input logic [31:0] w2, input logic [31:0] w1, input logic [31:0] w0);
`ifdef PCROSSBAR_CRC_EN
        load_cfg_crc(w2, w1, w0, 8'h00);
`else
        shift(w2); shift(w1); shift(w0);
`endif
    endtask

    // Monitor: compares every expectation whose due cycle has arrived.
    initial begin : mon
        exp_t e;
        int   drain;
        drain = 0;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                vectors++;
                if (e.due != cyc || dout_a !== e.da || dout_b !== e.db ||
                    err_a !== e.err || err_b !== e.err || busy_a !== e.busy ||
                    busy_b !== e.busy || (e.chk_po && po_a !== e.po)) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d due=%0d: got dout=%h/%h err=%b/%b busy=%b/%b prog_o=%h, want dout=%h/%h err=%b busy=%b prog_o=%h(chk=%0d)",
                             e.name, cyc, e.due, dout_a, dout_b, err_a, err_b, busy_a, busy_b,
                             po_a, e.da, e.db, e.err, e.busy, e.po, e.chk_po);
                end
            end
            if (stim_done) begin
                drain++;
                if (sb.size() == 0 || drain > 20) begin
                    while (sb.size() > 0) begin
                        e = sb.pop_front();
                        vectors++;
                        miscompares++;
                        $display("FAIL %s: never sampled, due cycle %0d, now %0d", e.name, e.due, cyc);
                    end
                    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                    $finish;
                end
            end
        end
    end

    initial begin
        res = 1'b1; prog_i = '0; prog_shft = 1'b0; prog_commit = 1'b0;
        prog_abort = 1'b0; din = '0;
        tick(); tick();
        res = 1'b0;
        tick();
        expect_at(0, "reset", 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();

        // Route: out0<-7, out1<-15 (invalid on N_IN=12), out6<-3, out15<-0.
        din = 16'h8089;
        load_cfg(32'h0008_0000, 32'h8000_0013, 32'h0000_03F7);
        prog_commit = 1'b1;
        expect_at(1, "t1_busy",  16'h0,    16'h0,    1'b0, 1'b1, 32'h0, 1'b0);
        expect_at(2, "t1_old",   16'h0,    16'h0,    1'b0, 1'b0, 32'h0, 1'b0);
        expect_at(3, "t1_route", 16'h8043, 16'h8041, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        prog_commit = 1'b0;
        tick(); tick();
        din = 16'h0001;
        expect_at(1, "t1_din",   16'h8000, 16'h8000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick(); tick();

        // Short load: commit errors, config kept, abort clears.
        shift(32'hFFFF_FFFF); shift(32'hFFFF_FFFF);
        prog_commit = 1'b1;
        expect_at(1, "t2_err",    16'h8000, 16'h8000, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        prog_commit = 1'b0;
        tick(); tick();
        expect_at(0, "t2_sticky", 16'h8000, 16'h8000, 1'b1, 1'b0, 32'h0, 1'b0);
        prog_abort = 1'b1;
        expect_at(1, "t2_abort",  16'h8000, 16'h8000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        prog_abort = 1'b0;
        tick();

        // Shift and commit together: commit wins, extra word dropped.
        din = 16'h0004;
        tick();
        load_cfg(32'h4000_0000, 32'h0, 32'h0000_0012);
        prog_i = 32'hDEAD_BEEF; prog_shft = 1'b1; prog_commit = 1'b1;
        expect_at(1, "t3_busy",    16'h0,    16'h0,    1'b0, 1'b1, 32'h4000_0000, 1'b1);
        expect_at(2, "t3_noshift", 16'h0,    16'h0,    1'b0, 1'b0, 32'h4000_0000, 1'b1);
        expect_at(3, "t3_route",   16'h0001, 16'h0001, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        prog_shft = 1'b0; prog_commit = 1'b0;
        tick(); tick(); tick();

        // Reset in the middle of COMMIT leaves everything disabled.
        din = 16'hFFFF;
        load_cfg(32'h0, 32'h0, 32'h0000_0017);
        prog_commit = 1'b1;
        tick();
        prog_commit = 1'b0;
        res = 1'b1;
        expect_at(0, "t4_reset", 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(); tick();
        res = 1'b0;
        tick();
        expect_at(1, "t4_disabled", 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick(); tick();

        // Overshift (count saturates past C) and empty commit both error.
        repeat (C + 1) shift(32'h0);
        prog_commit = 1'b1;
        expect_at(1, "t6_overshift", 16'h0, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        prog_commit = 1'b0; prog_abort = 1'b1;
        expect_at(1, "t6_abort", 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        prog_abort = 1'b0;
        prog_commit = 1'b1;
        expect_at(1, "t6_empty", 16'h0, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        prog_commit = 1'b0; prog_abort = 1'b1;
        expect_at(1, "t6_abort2", 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        prog_abort = 1'b0;
        tick();

`ifdef PCROSSBAR_CRC_EN
        din = 16'h0080;
        load_cfg_crc(32'h0, 32'h0, 32'h0000_0017, 8'h00);
        prog_commit = 1'b1;
        expect_at(3, "t5_crc_good", 16'h0001, 16'h0001, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        prog_commit = 1'b0;
        tick(); tick(); tick();
        load_cfg_crc(32'h0, 32'h0, 32'h0000_0000, 8'h01);
        prog_commit = 1'b1;
        expect_at(1, "t5_crc_bad", 16'h0001, 16'h0001, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        prog_commit = 1'b0; prog_abort = 1'b1;
        tick();
        prog_abort = 1'b0;
        tick();
`endif

        stim_done = 1'b1;
    end

endmodule
